// File: rtl/spi_eeprom_read_arbiter_if.sv
// Requester-side bundle for the shared SPI EEPROM read arbiter.
// Two requesters, each with its own request/grant/strobe set.
interface spi_eeprom_read_arbiter_if;
    logic       req0;
    logic [7:0] addr0;
    logic [7:0] len0;
    logic       gnt0;
    logic       rvalid0;
    logic       done0;
    logic       req1;
    logic [7:0] addr1;
    logic [7:0] len1;
    logic       gnt1;
    logic       rvalid1;
    logic       done1;
    logic [7:0] rdata;

    modport master (
        output req0, addr0, len0,
        output req1, addr1, len1,
        input  gnt0, rvalid0, done0,
        input  gnt1, rvalid1, done1,
        input  rdata
    );

    modport slave (
        input  req0, addr0, len0,
        input  req1, addr1, len1,
        output gnt0, rvalid0, done0,
        output gnt1, rvalid1, done1,
        output rdata
    );
endinterface

// File: rtl/spi_eeprom_read_arbiter.sv
// Round-robin burst arbiter in front of one SPI EEPROM (READ 0x03).
// Sends command and address, then streams data bytes to the owner.
module spi_eeprom_read_arbiter #(
    parameter int CLK_DIV = 1,
    parameter int CS_IDLE = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    spi_eeprom_read_arbiter_if.slave        bus,
    output logic                            busy,
    output logic                            spi_cs_n,
    output logic                            spi_sck,
    output logic                            spi_copi,
    input  logic                            spi_cipo
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);
    localparam logic [7:0] CMD_READ = 8'h03;

    logic [2:0] state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;
    logic       own_q, own_d;
    logic       last_q, last_d;
    logic       abrt_q, abrt_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       rv0_q, rv0_d;
    logic       rv1_q, rv1_d;
    logic       dn0_q, dn0_d;
    logic       dn1_q, dn1_d;
    logic [7:0] rdata_q, rdata_d;
    logic       cs_q, cs_d;
    logic       sck_q, sck_d;
    logic       copi_q, copi_d;
    logic       req_own, stop, pick;

    // Next-state logic: arbitration, bit timing, shifting and byte delivery.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        own_d   = own_q;
        last_d  = last_q;
        abrt_d  = abrt_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        dn0_d   = 1'b0;
        dn1_d   = 1'b0;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        copi_d  = copi_q;
        req_own = own_q ? bus.req1 : bus.req0;
        stop    = abrt_q | ~req_own;
        pick    = bus.req1 & (~bus.req0 | ~last_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d = ST_CMD;
                    own_d   = pick;
                    last_d  = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    addr_d  = pick ? bus.addr1 : bus.addr0;
                    len_d   = pick ? bus.len1 : bus.len0;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    sh_d    = CMD_READ;
                    copi_d  = CMD_READ[7];
                    div_d   = 8'd0;
                    bit_d   = 3'd0;
                    cnt_d   = 8'd0;
                    abrt_d  = 1'b0;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                abrt_d = stop;
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_d = {rx_q[6:0], spi_cipo};
                    end else begin
                        bit_d = bit_q + 3'd1;
                        if (state_q != ST_DATA && stop) begin
                            state_d = ST_FIN;
                            copi_d  = 1'b0;
                            dn0_d   = ~own_q;
                            dn1_d   = own_q;
                        end else if (bit_q != 3'd7) begin
                            sh_d   = {sh_q[6:0], 1'b0};
                            copi_d = sh_q[6];
                        end else if (state_q == ST_CMD) begin
                            state_d = ST_ADDR;
                            sh_d    = addr_q;
                            copi_d  = addr_q[7];
                        end else if (state_q == ST_ADDR) begin
                            state_d = ST_DATA;
                            sh_d    = 8'd0;
                            copi_d  = 1'b0;
                        end else begin
                            rdata_d = rx_q;
                            rv0_d   = ~own_q;
                            rv1_d   = own_q;
                            cnt_d   = cnt_q + 8'd1;
                            if (cnt_q == len_q || stop) begin
                                state_d = ST_FIN;
                                dn0_d   = ~own_q;
                                dn1_d   = own_q;
                            end
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_GAP;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                copi_d  = 1'b0;
                gap_d   = 8'd0;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else gap_d = gap_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous return to the idle bus state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            rx_q    <= 8'd0;
            addr_q  <= 8'd0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            gap_q   <= 8'd0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            abrt_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            dn0_q   <= 1'b0;
            dn1_q   <= 1'b0;
            rdata_q <= 8'd0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            copi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            own_q   <= own_d;
            last_q  <= last_d;
            abrt_q  <= abrt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            dn0_q   <= dn0_d;
            dn1_q   <= dn1_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            copi_q  <= copi_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.rvalid0 = rv0_q;
    assign bus.rvalid1 = rv1_q;
    assign bus.done0   = dn0_q;
    assign bus.done1   = dn1_q;
    assign bus.rdata   = rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign spi_cs_n    = cs_q;
    assign spi_sck     = sck_q;
    assign spi_copi    = copi_q;
endmodule

// File: doc/spi_eeprom_read_arbiter.md
Name: spi_eeprom_read_arbiter

Overview:
Shares the single external SPI serial EEPROM (READ command 0x03, 8-bit address, sequential read) between two on-chip requesters. Requester 0 is the instruction fetcher; requester 1 is the configuration/period loader. The block owns CS/SCK/COPI/CIPO and arbitrates whole burst transactions round-robin. It generates the command and address phases, then streams data bytes back to the granted requester.

Parameters:
CLK_DIV, 1, SCK half-period in clk cycles (>=1); one SPI bit = 2*CLK_DIV clk cycles
CS_IDLE, 2, minimum clk cycles spi_cs_n held high between transactions (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 transaction request, held until done0 or abort
addr0  in  8  requester 0 start address, sampled at grant
len0  in  8  requester 0 byte count minus 1 (0 = 1 byte, 255 = 256 bytes), sampled at grant
gnt0  out  1  requester 0 owns the EEPROM
rvalid0  out  1  one-cycle pulse: rdata holds the next byte for requester 0
done0  out  1  one-cycle pulse: requester 0 transaction finished
req1, addr1, len1, gnt1, rvalid1, done1: same as above, for requester 1
rdata  out  8  shared read byte, valid when rvalid0 or rvalid1 is high
busy  out  1  high in any state other than IDLE
spi_cs_n  out  1  EEPROM chip select, active low
spi_sck  out  1  EEPROM clock, idle low (SPI mode 0)
spi_copi  out  1  data to EEPROM, MSB first
spi_cipo  in  1  data from EEPROM

Behaviour:
- Reset values (async): state=IDLE, spi_cs_n=1, spi_sck=0, spi_copi=0, all gnt/rvalid/done=0, rdata=0, busy=0, last_served=1, so requester 0 wins the first tie.
- States: IDLE -> CMD (8 bits) -> ADDR (8 bits) -> DATA (8 bits per byte, repeated) -> GAP -> IDLE.
- IDLE: if any req is high, grant at the next edge. If only one is requesting, grant it. If both are requesting, grant the one that is not last_served. On the grant edge: gnt=1, spi_cs_n=0, addr/len latched, last_served updated, state=CMD, spi_copi driven with bit 7 of 0x03.
- Bit timing: spi_sck is low for CLK_DIV cycles, then high for CLK_DIV cycles. spi_copi changes only while spi_sck is low (on the falling-edge cycle). spi_cipo is sampled on the cycle spi_sck rises. First rise occurs CLK_DIV cycles after grant.
- CMD shifts out 0x03, then ADDR shifts out the latched address, both MSB first.
- DATA shifts in 8 bits MSB first. spi_copi=0 during DATA.
- Byte k (k=0..len) is presented with rdata and rvalidN=1 exactly 2*CLK_DIV*(24+8k) cycles after the grant edge. rvalid is asserted for exactly one cycle.
- After byte len: doneN pulses in the same cycle as the last rvalidN. On the next cycle gntN=0, spi_cs_n=1, spi_sck=0, state=GAP.
- GAP: hold spi_cs_n high for CS_IDLE cycles, then go to IDLE. A new grant is possible on the cycle after IDLE is entered.
- Abort: if the granted req drops during CMD/ADDR/DATA, the current bit period completes, and the current byte is finished if in DATA (its rvalid is still issued). doneN then pulses and the block goes to GAP. doneN pulses even on abort.
- The EEPROM internal address wraps from 0xFF to 0x00. The block does not track or correct this; len 255 from addr 0x01 ends with byte from 0x00.
- A req asserted by the non-granted side is held pending and is never lost. The other requester is never granted before GAP completes.
- gnt0 and gnt1 are never high simultaneously. rvalidN is only ever asserted while gntN is high.
- Reset mid-transaction: all outputs return to reset values immediately and asynchronously. No done pulse is issued.
- len and addr inputs are ignored outside the grant edge.

Test Plan:
- CLK_DIV=1, req0 with addr0=0x10, len0=0, EEPROM model returns 0xA5 -> COPI bits 0x03 then 0x10; rvalid0 with rdata=0xA5 at grant+48 cycles; done0 in the same cycle; spi_cs_n high for 2 cycles; gnt0 then drops.
- req0 and req1 both asserted in the first cycle after reset -> gnt0 first; gnt1 granted after GAP; the next simultaneous request goes to gnt0 again (round-robin). gnt0 and gnt1 never overlap.
- req1 with addr1=0xFE, len1=3, model memory [n]=n -> rdata sequence 0xFE, 0xFF, 0x00, 0x01 on four rvalid1 pulses, spaced 16 cycles apart.
- req0 with len0=7, req0 dropped at the 20th DATA bit -> bytes 0..2 delivered; done0 after byte 2; spi_cs_n high; no further rvalid0.
- rst_n pulsed low mid-ADDR -> spi_cs_n=1, spi_sck=0, gnt0=0 in the same cycle without waiting for clk. After release, a pending req0 is re-granted starting from CMD.
- CLK_DIV=3, len0=0 -> spi_sck high/low for 3 cycles each; rvalid0 at grant+144 cycles.
